// File: rtl/correlation_pkg.sv
// ----------------------------------------------------------------------------
// correlation_pkg
// Shared definitions for the correlation scheduler slice.
//   - sched_state_t : scheduler FSM state encoding
//   - LAG_BITS      : width of the lag index sent to the correlator engine
//   - num_pairs / num_results / idx_bits : sizing helpers derived from the
//     channel count and lags per pair
// ----------------------------------------------------------------------------
package correlation_pkg;

    localparam int LAG_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_t;

    // Number of unordered channel pairs (a,b) with a < b.
    function automatic int num_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Total results produced for one frame.
    function automatic int num_results(input int n, input int lags);
        return num_pairs(n) * lags;
    endfunction

    // Width needed to index every result of a frame.
    function automatic int idx_bits(input int n, input int lags);
        return $clog2(num_results(n, lags));
    endfunction

endpackage

// File: rtl/correlation_scheduler_pair_counter.sv
// ----------------------------------------------------------------------------
// pair_counter
// Walks through every channel pair (ch_a, ch_b), ch_a < ch_b, in
// lexicographic order: (0,1),(0,2),..,(0,N-1),(1,2),..,(N-2,N-1).
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : return to the first pair (0,1)
//   advance    : step to the next pair (wraps to (0,1) after the last one)
//   ch_a, ch_b : current pair
//   last       : current pair is (N-2, N-1)
// ----------------------------------------------------------------------------
module pair_counter #(
    parameter  int NUM_SLAVES = 4,
    localparam int CH_BITS    = $clog2(NUM_SLAVES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [CH_BITS-1:0] ch_a,
    output logic [CH_BITS-1:0] ch_b,
    output logic               last
);

    logic b_at_top;

    assign b_at_top = (ch_b == CH_BITS'(NUM_SLAVES - 1));
    assign last     = b_at_top && (ch_a == CH_BITS'(NUM_SLAVES - 2));

    // Pair register. Clear has priority over advance so an abort that lands
    // on a pair boundary still restarts from (0,1). When ch_b runs out, ch_a
    // steps and ch_b restarts just above it, which keeps ch_a < ch_b.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_a <= '0;
            ch_b <= CH_BITS'(1);
        end else if (clear) begin
            ch_a <= '0;
            ch_b <= CH_BITS'(1);
        end else if (advance) begin
            if (last) begin
                ch_a <= '0;
                ch_b <= CH_BITS'(1);
            end else if (b_at_top) begin
                ch_a <= ch_a + CH_BITS'(1);
                ch_b <= ch_a + CH_BITS'(2);
            end else begin
                ch_b <= ch_b + CH_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/correlation_scheduler.sv
// ----------------------------------------------------------------------------
// correlation_scheduler
// Sequences one shared correlator engine through every channel pair and lag
// of a sample frame and forwards each result, tagged with its index
// (pairIndex*MAX_LAGS + lag), toward the CPU peripheral.
// Ports:
//   clk, reset             : system clock, asynchronous active-high reset
//   frameReady             : pulse, a new frame is stored for all channels
//   abort                  : drop the frame currently being processed
//   corrStart              : pulse to the engine, with corrChA/corrChB/corrLag
//   corrChA, corrChB       : channel pair under correlation (corrChA < corrChB)
//   corrLag                : lag index 0..MAX_LAGS-1
//   corrDone, corrResult   : engine completion pulse and its signed result
//   dataOut, dataOutIdx    : last result and its index (held between strobes)
//   dataOutValid           : one-cycle strobe qualifying dataOut/dataOutIdx
//   frameDone              : pulse after the last result of a frame
//   busy                   : scheduler is not idle
//   frameOverrun           : sticky, a frame arrived while busy
// ----------------------------------------------------------------------------
module correlation_scheduler
    import correlation_pkg::*;
#(
    parameter  int NUM_SLAVES  = 4,
    parameter  int MAX_LAGS    = 17,
    parameter  int CPU_BITS    = 32,
    localparam int NUM_RESULTS = num_results(NUM_SLAVES, MAX_LAGS),
    localparam int IDX_BITS    = idx_bits(NUM_SLAVES, MAX_LAGS),
    localparam int CH_BITS     = $clog2(NUM_SLAVES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frameReady,
    input  logic                abort,
    output logic                corrStart,
    output logic [CH_BITS-1:0]  corrChA,
    output logic [CH_BITS-1:0]  corrChB,
    output logic [LAG_BITS-1:0] corrLag,
    input  logic                corrDone,
    input  logic [CPU_BITS-1:0] corrResult,
    output logic [CPU_BITS-1:0] dataOut,
    output logic [IDX_BITS-1:0] dataOutIdx,
    output logic                dataOutValid,
    output logic                frameDone,
    output logic                busy,
    output logic                frameOverrun
);

    sched_state_t        state;
    sched_state_t        state_next;
    logic [LAG_BITS-1:0] lag;
    logic [IDX_BITS-1:0] result_idx;
    logic                last_lag;
    logic                pair_last;
    logic                pair_clear;
    logic                pair_advance;
    logic                aborting;
    logic                capture;

    assign last_lag = (lag == LAG_BITS'(MAX_LAGS - 1));
    assign aborting = abort && (state != ST_IDLE);
    assign capture  = (state == ST_WAIT) && corrDone && !abort;

    pair_counter #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_pair_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (pair_clear),
        .advance (pair_advance),
        .ch_a    (corrChA),
        .ch_b    (corrChB),
        .last    (pair_last)
    );

    assign corrLag = lag;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The pair only steps when the lag wraps, and the frame
    // ends once the final pair has emitted its final lag. An abort outside
    // IDLE overrides everything and rewinds the pair counter; in IDLE the
    // abort is meaningless, so a coincident frameReady still starts a frame.
    always_comb begin
        state_next   = state;
        pair_clear   = 1'b0;
        pair_advance = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frameReady) begin
                    state_next = ST_ISSUE;
                    pair_clear = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (corrDone) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                pair_advance = last_lag;
                if (last_lag && pair_last) begin
                    state_next = ST_FINISH;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (aborting) begin
            state_next   = ST_IDLE;
            pair_clear   = 1'b1;
            pair_advance = 1'b0;
        end
    end

    // Strobes are decoded from the state, but an abort in the same cycle
    // suppresses them so nothing more leaves for a frame being dropped.
    assign corrStart    = (state == ST_ISSUE)  && !abort;
    assign dataOutValid = (state == ST_EMIT)   && !abort;
    assign frameDone    = (state == ST_FINISH) && !abort;
    assign busy         = (state != ST_IDLE);

    // Lag and running result index. Results leave strictly in pair/lag
    // order, so a plain counter bumped on every EMIT equals
    // pairIndex*MAX_LAGS + lag without needing a multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lag        <= '0;
            result_idx <= '0;
        end else if (pair_clear) begin
            lag        <= '0;
            result_idx <= '0;
        end else if (state == ST_EMIT) begin
            lag        <= last_lag ? '0 : lag + LAG_BITS'(1);
            result_idx <= result_idx + IDX_BITS'(1);
        end
    end

    // Output holding registers. The engine result is only valid during its
    // corrDone pulse, so it is latched together with its index and held
    // until the next result replaces it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOut    <= '0;
            dataOutIdx <= '0;
        end else if (capture) begin
            dataOut    <= corrResult;
            dataOutIdx <= result_idx;
        end
    end

    // Overrun flag. Any frameReady the FSM cannot accept (including the
    // FINISH cycle) is recorded here and only reset can clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameOverrun <= 1'b0;
        end else if (frameReady && (state != ST_IDLE)) begin
            frameOverrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_correlation_scheduler.sv
// ----------------------------------------------------------------------------
// tb_correlation_scheduler
// Self-checking bench for correlation_scheduler at default parameters. A
// behavioural engine answers every corrStart with corrResult = {chA,chB,lag};
// the expected result stream of each frame is queued when the frame is
// launched and compared strobe by strobe.
// ----------------------------------------------------------------------------
module tb_correlation_scheduler;

    localparam int NUM_SLAVES  = 4;
    localparam int MAX_LAGS    = 17;
    localparam int CPU_BITS    = 32;
    localparam int NUM_RESULTS = 102;
    localparam int IDX_BITS    = 7;
    localparam int CH_BITS     = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                frameReady;
    logic                abort;
    logic                corrStart;
    logic [CH_BITS-1:0]  corrChA;
    logic [CH_BITS-1:0]  corrChB;
    logic [4:0]          corrLag;
    logic                corrDone;
    logic [CPU_BITS-1:0] corrResult;
    logic [CPU_BITS-1:0] dataOut;
    logic [IDX_BITS-1:0] dataOutIdx;
    logic                dataOutValid;
    logic                frameDone;
    logic                busy;
    logic                frameOverrun;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int          cycle = 0;
    int          start_count = 0;
    int          strobe_count = 0;
    int          done_count = 0;
    int          last_emit_cycle = 0;
    int          done_cycle = 0;
    int          first_issue_cycle = 0;
    logic        issue_armed = 1'b0;
    int          engine_delay = 1;
    logic        eng_pending = 1'b0;
    int          eng_count = 0;
    logic [1:0]  eng_a;
    logic [1:0]  eng_b;
    logic [4:0]  eng_lag;
    int          base_strobes;
    int          base_starts;
    int          budget;

    correlation_scheduler #(
        .NUM_SLAVES (NUM_SLAVES),
        .MAX_LAGS   (MAX_LAGS),
        .CPU_BITS   (CPU_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frameReady   (frameReady),
        .abort        (abort),
        .corrStart    (corrStart),
        .corrChA      (corrChA),
        .corrChB      (corrChB),
        .corrLag      (corrLag),
        .corrDone     (corrDone),
        .corrResult   (corrResult),
        .dataOut      (dataOut),
        .dataOutIdx   (dataOutIdx),
        .dataOutValid (dataOutValid),
        .frameDone    (frameDone),
        .busy         (busy),
        .frameOverrun (frameOverrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, actual, expected, cycle);
        end
    endtask

    // Queue the full expected result stream of one frame.
    task automatic pushFrame();
        exp_t e;
        int   idx = 0;
        for (int a = 0; a < NUM_SLAVES - 1; a++) begin
            for (int b = a + 1; b < NUM_SLAVES; b++) begin
                for (int l = 0; l < MAX_LAGS; l++) begin
                    e.idx  = 32'(idx);
                    e.data = 32'(a * 128 + b * 32 + l);
                    sb_q.push_back(e);
                    idx++;
                end
            end
        end
    endtask

    // One clock: sample DUT outputs at the falling edge, score them, then
    // run the engine model and drive its inputs for the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cycle++;
        if (dataOutValid) begin
            strobe_count++;
            last_emit_cycle = cycle;
            checkOutput("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("out_idx", 64'(dataOutIdx), 64'(e.idx));
                checkOutput("out_data", 64'(dataOut), 64'(e.data));
            end
        end
        if (frameDone) begin
            done_count++;
            done_cycle = cycle;
            checkOutput("done_after_last", 64'(cycle - last_emit_cycle), 64'd1);
            checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
        end
        if (corrStart) begin
            start_count++;
            if (issue_armed) begin
                first_issue_cycle = cycle;
                issue_armed = 1'b0;
            end
        end
        corrDone = 1'b0;
        if (eng_pending) begin
            eng_count--;
            if (eng_count == 0) begin
                eng_pending = 1'b0;
                if (busy) begin
                    checkOutput("pair_lag_stable", 64'({corrChA, corrChB, corrLag}),
                                64'({eng_a, eng_b, eng_lag}));
                end
                corrDone   = 1'b1;
                corrResult = CPU_BITS'({eng_a, eng_b, eng_lag});
            end
        end
        if (corrStart) begin
            eng_pending = 1'b1;
            eng_count   = engine_delay;
            eng_a       = corrChA;
            eng_b       = corrChB;
            eng_lag     = corrLag;
        end
    endtask

    // Launch a frame and queue its expected results.
    task automatic applyStimulus();
        pushFrame();
        issue_armed = 1'b1;
        frameReady  = 1'b1;
        tick();
        frameReady  = 1'b0;
    endtask

    task automatic waitFrameDone(input int limit);
        int base = done_count;
        int n = 0;
        while (done_count == base && n < limit) begin
            tick();
            n++;
        end
        checkOutput("frame_done_seen", 64'(done_count - base), 64'd1);
    endtask

    task automatic waitStarts(input int target, input int limit);
        int n = 0;
        while (start_count < target && n < limit) begin
            tick();
            n++;
        end
        checkOutput("start_reached", 64'(start_count), 64'(target));
    endtask

    task automatic waitStrobes(input int target, input int limit);
        int n = 0;
        while (strobe_count < target && n < limit) begin
            tick();
            n++;
        end
        checkOutput("strobe_reached", 64'(strobe_count), 64'(target));
    endtask

    task automatic checkReset();
        checkOutput("rst_corrStart", 64'(corrStart), 64'd0);
        checkOutput("rst_valid", 64'(dataOutValid), 64'd0);
        checkOutput("rst_frameDone", 64'(frameDone), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_overrun", 64'(frameOverrun), 64'd0);
        checkOutput("rst_dataOut", 64'(dataOut), 64'd0);
        checkOutput("rst_dataOutIdx", 64'(dataOutIdx), 64'd0);
        checkOutput("rst_chA", 64'(corrChA), 64'd0);
        checkOutput("rst_chB", 64'(corrChB), 64'd1);
        checkOutput("rst_lag", 64'(corrLag), 64'd0);
    endtask

    // Assert reset mid-operation; in-flight engine work and queued
    // expectations belong to the dropped frame.
    task automatic pulseReset();
        reset       = 1'b1;
        eng_pending = 1'b0;
        corrDone    = 1'b0;
        sb_q.delete();
        tick();
        checkReset();
        tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        frameReady = 1'b0;
        abort      = 1'b0;
        corrDone   = 1'b0;
        corrResult = '0;
        reset      = 1'b1;
        tick();
        tick();
        checkReset();
        reset = 1'b0;
        repeat (2) tick();

        // Full frame, engine answers one cycle after each start.
        $display("[TB] full frame, engine delay 1");
        engine_delay = 1;
        base_strobes = strobe_count;
        applyStimulus();
        waitFrameDone(400);
        checkOutput("frame_cycles", 64'(done_cycle - first_issue_cycle + 1), 64'd307);
        checkOutput("frame_strobes", 64'(strobe_count - base_strobes), 64'(NUM_RESULTS));
        checkOutput("hold_data", 64'(dataOut), 64'(2 * 128 + 3 * 32 + 16));
        checkOutput("hold_idx", 64'(dataOutIdx), 64'd101);
        checkOutput("no_overrun", 64'(frameOverrun), 64'd0);
        repeat (3) tick();

        // Frame arriving while busy is ignored but flagged.
        $display("[TB] overrun during frame, engine delay 5");
        engine_delay = 5;
        base_strobes = strobe_count;
        applyStimulus();
        waitStrobes(base_strobes + 40, 1000);
        frameReady = 1'b1;
        tick();
        frameReady = 1'b0;
        checkOutput("overrun_set", 64'(frameOverrun), 64'd1);
        waitFrameDone(2000);
        checkOutput("overrun_strobes", 64'(strobe_count - base_strobes), 64'(NUM_RESULTS));
        repeat (5) tick();
        checkOutput("overrun_sticky", 64'(frameOverrun), 64'd1);
        checkOutput("overrun_idle", 64'(busy), 64'd0);
        pulseReset();

        // Abort one cycle after the 10th start, coincident with its corrDone.
        $display("[TB] abort after 10th start");
        engine_delay = 1;
        base_strobes = strobe_count;
        base_starts  = start_count;
        applyStimulus();
        waitStarts(base_starts + 10, 200);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("busy_after_abort", 64'(busy), 64'd0);
        sb_q.delete();
        repeat (20) tick();
        checkOutput("abort_strobes", 64'(strobe_count - base_strobes), 64'd9);
        checkOutput("abort_starts", 64'(start_count - base_starts), 64'd10);
        base_strobes = strobe_count;
        applyStimulus();
        waitFrameDone(400);
        checkOutput("restart_strobes", 64'(strobe_count - base_strobes), 64'(NUM_RESULTS));
        repeat (3) tick();

        // Reset during the wait for result 50, then a clean frame.
        $display("[TB] reset during result 50");
        engine_delay = 5;
        base_starts  = start_count;
        applyStimulus();
        waitStarts(base_starts + 51, 2000);
        tick();
        tick();
        pulseReset();
        engine_delay = 1;
        base_strobes = strobe_count;
        applyStimulus();
        waitFrameDone(400);
        checkOutput("post_reset_strobes", 64'(strobe_count - base_strobes), 64'(NUM_RESULTS));

        // frameReady in the FINISH cycle counts as overrun and is dropped.
        frameReady = 1'b1;
        tick();
        frameReady = 1'b0;
        checkOutput("finish_overrun", 64'(frameOverrun), 64'd1);
        budget = 0;
        repeat (3) begin
            tick();
            budget += int'(busy);
        end
        checkOutput("finish_ready_ignored", 64'(budget), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/correlation_scheduler.md
CORRELATION_SCHEDULER -- requirements
Module: correlation_scheduler

Interface
REQ-001 Parameter NUM_SLAVES, default 4, number of SPI microphone channels; SHALL be >= 2.
REQ-002 Parameter MAX_LAGS, default 17, correlation lags per channel pair; SHALL be < 32.
REQ-003 Parameter CPU_BITS, default 32, width of correlation results and CPU words.
REQ-004 Derived constants: NUM_PAIRS = NUM_SLAVES*(NUM_SLAVES-1)/2 (6 at defaults); NUM_RESULTS = NUM_PAIRS*MAX_LAGS (102 at defaults); IDX_BITS = clog2(NUM_RESULTS).
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 frameReady  in  1  one-cycle pulse: new sample frame is stored for all channels.
REQ-008 abort  in  1  synchronous request to drop the current frame.
REQ-009 corrStart  out  1  one-cycle pulse to the shared correlator engine.
REQ-010 corrChA, corrChB  out  clog2(NUM_SLAVES) each  channel pair, with corrChA < corrChB.
REQ-011 corrLag  out  5  lag index, 0..MAX_LAGS-1.
REQ-012 corrDone  in  1  one-cycle pulse from the engine; corrResult is valid in the same cycle.
REQ-013 corrResult  in  CPU_BITS  signed correlation value.
REQ-014 dataOut  out  CPU_BITS  result toward the CPU peripheral.
REQ-015 dataOutIdx  out  IDX_BITS  result index: pairIndex*MAX_LAGS + lag.
REQ-016 dataOutValid  out  1  one-cycle strobe qualifying dataOut and dataOutIdx.
REQ-017 frameDone  out  1  one-cycle pulse after the last result of a frame.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frameOverrun  out  1  sticky flag; set when frameReady arrives while busy.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, EMIT, FINISH.
REQ-021 IDLE: on frameReady=1, clear pair/lag counters to 0 and enter ISSUE on the next cycle.
REQ-022 ISSUE: drive corrStart=1 for exactly one cycle with the current chA/chB/lag, then enter WAIT.
REQ-023 corrChA, corrChB and corrLag SHALL stay stable from ISSUE until the matching corrDone.
REQ-024 WAIT: on corrDone=1, register corrResult and enter EMIT; otherwise remain in WAIT.
REQ-025 EMIT: dataOutValid=1 for one cycle with the registered result and its index; dataOut holds its value at all other times.
REQ-026 After EMIT, advance the lag. At lag MAX_LAGS-1, wrap the lag to 0 and advance the pair. Pair order is lexicographic: (0,1),(0,2),..,(0,N-1),(1,2),..,(N-2,N-1).
REQ-027 After EMIT of the last pair at lag MAX_LAGS-1, enter FINISH; otherwise enter ISSUE.
REQ-028 FINISH: frameDone=1 for one cycle, then enter IDLE.
REQ-029 Per-result latency: ISSUE -> corrStart, then engine delay, then EMIT one cycle after corrDone. Minimum period is 3 cycles when corrDone arrives the cycle after corrStart.
REQ-030 frameReady in any state other than IDLE SHALL be ignored and SHALL set frameOverrun. frameReady in the same cycle that FINISH exits to IDLE also counts as overrun.
REQ-031 frameOverrun SHALL clear only on reset.
REQ-032 corrDone outside WAIT SHALL be ignored.
REQ-033 abort in any non-IDLE state: next state is IDLE. No further corrStart, dataOutValid or frameDone for that frame. Counters clear to 0.
REQ-034 abort and corrDone in the same cycle: abort wins, and the result is discarded.
REQ-035 abort and frameReady in the same cycle while IDLE: frameReady wins, and the frame starts.
REQ-036 Exactly NUM_RESULTS dataOutValid strobes per completed frame, with indices strictly increasing from 0 to NUM_RESULTS-1.

Reset
REQ-037 reset asserted at any time, including mid-frame: state=IDLE, corrStart=0, dataOutValid=0, frameDone=0, busy=0, frameOverrun=0, dataOut=0, dataOutIdx=0, corrChA=0, corrChB=1, corrLag=0.
REQ-038 After reset deasserts, the first frameReady SHALL start a frame normally.

Structure
REQ-039 Shared package correlation_pkg: FSM state enum; NUM_PAIRS/NUM_RESULTS/IDX_BITS helper functions; lag width constant (5).
REQ-040 One sub-module, pair_counter: generates (chA,chB) in lexicographic order with advance, clear and last outputs.
REQ-041 Target size: 150-300 lines of RTL.

Verification
REQ-042 Defaults; engine replies corrDone 1 cycle after every corrStart; one frameReady -> 102 dataOutValid strobes, indices 0..101; frameDone 1 cycle after index 101; total 307 cycles from ISSUE to FINISH.
REQ-043 Engine returns corrResult = {chA,chB,lag} encoded -> index 17 carries pair (0,2), lag 0; index 101 carries pair (2,3), lag 16.
REQ-044 Engine delay of 5 cycles; frameReady pulsed at result 40 -> frame completes unaffected; frameOverrun=1 and stays 1 until reset.
REQ-045 abort in the cycle after the 10th corrStart -> busy=0 next cycle; no further strobes; a new frameReady restarts at index 0.
REQ-046 abort coincident with corrDone -> no dataOutValid for that result.
REQ-047 reset asserted during WAIT of result 50 -> all outputs at reset values; following frame emits indices 0..101.
